// File: rtl/codec_sample_feeder.sv
// Stereo PCM FIFO feeding the AC97 codec interface; the presented pair changes
// only in the cycle the codec sees a rising edge of PCM_Playback_Accept.
module codec_sample_feeder #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sample_left,
  input  logic [WIDTH-1:0] sample_right,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic             PCM_Playback_Accept,
  output logic [WIDTH-1:0] PCM_Playback_Left,
  output logic [WIDTH-1:0] PCM_Playback_Right,
  output logic [AW:0]      fill_level,
  output logic             underrun,
  output logic [7:0]       underrun_count
);

  logic [WIDTH-1:0] r_mem_l [DEPTH];
  logic [WIDTH-1:0] r_mem_r [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_held_l;
  logic [WIDTH-1:0] r_held_r;
  logic             r_accept_q;
  logic             r_alive;
  logic             r_underrun;
  logic [7:0]       r_urun_cnt;

  logic             w_frame;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_head_l;
  logic [WIDTH-1:0] w_head_r;

  assign w_frame      = PCM_Playback_Accept & ~r_accept_q;
  assign fill_level   = r_wptr - r_rptr;
  assign w_empty      = (r_wptr == r_rptr);
  assign w_full       = (fill_level == (AW+1)'(DEPTH));
  // r_alive keeps ready low during reset and for the release cycle
  assign sample_ready = r_alive & ~w_full;
  assign w_push       = sample_valid & sample_ready;
  assign w_pop        = w_frame & ~w_empty;
  assign w_head_l     = r_mem_l[r_rptr[AW-1:0]];
  assign w_head_r     = r_mem_r[r_rptr[AW-1:0]];

  assign underrun       = r_underrun;
  assign underrun_count = r_urun_cnt;

  // Head is forwarded in the frame cycle so the codec latches the new pair
  // on the same edge that moves it into the held registers.
  always_comb begin
    PCM_Playback_Left  = r_held_l;
    PCM_Playback_Right = r_held_r;
    if (w_pop) begin
      PCM_Playback_Left  = w_head_l;
      PCM_Playback_Right = w_head_r;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_l[r_wptr[AW-1:0]] <= sample_left;
      r_mem_r[r_wptr[AW-1:0]] <= sample_right;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_held_l   <= '0;
      r_held_r   <= '0;
      r_accept_q <= 1'b0;
      r_alive    <= 1'b0;
      r_underrun <= 1'b0;
      r_urun_cnt <= '0;
    end else begin
      r_alive    <= 1'b1;
      r_accept_q <= PCM_Playback_Accept;
      r_underrun <= w_frame & w_empty;
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop) begin
        r_rptr   <= r_rptr + (AW+1)'(1);
        r_held_l <= w_head_l;
        r_held_r <= w_head_r;
      end
      if (w_frame && w_empty && r_urun_cnt != 8'hFF)
        r_urun_cnt <= r_urun_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_codec_sample_feeder.sv
// Directed bench for codec_sample_feeder: handshake, frame-aligned output,
// underrun counting, reset mid-stream and a streamed ramp against a queue model.
module tb_codec_sample_feeder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] sample_left;
  logic [15:0] sample_right;
  logic        sample_valid;
  logic        sample_ready;
  logic        PCM_Playback_Accept;
  logic [15:0] PCM_Playback_Left;
  logic [15:0] PCM_Playback_Right;
  logic [2:0]  fill_level;
  logic        underrun;
  logic [7:0]  underrun_count;

  int n_checks = 0;
  int n_errors = 0;

  codec_sample_feeder #(.WIDTH(16), .DEPTH(4), .AW(2)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .sample_left         (sample_left),
    .sample_right        (sample_right),
    .sample_valid        (sample_valid),
    .sample_ready        (sample_ready),
    .PCM_Playback_Accept (PCM_Playback_Accept),
    .PCM_Playback_Left   (PCM_Playback_Left),
    .PCM_Playback_Right  (PCM_Playback_Right),
    .fill_level          (fill_level),
    .underrun            (underrun),
    .underrun_count      (underrun_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    sample_left  = l;
    sample_right = r;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  // Drives one Accept rising edge, checks the pair shown in the frame cycle, then drops Accept.
  task automatic frame_chk(input string tag, input logic [15:0] l, input logic [15:0] r);
    PCM_Playback_Accept = 1'b1;
    #1;
    chk({tag, "_L"}, 32'(PCM_Playback_Left), 32'(l));
    chk({tag, "_R"}, 32'(PCM_Playback_Right), 32'(r));
    tick();
    PCM_Playback_Accept = 1'b0;
    tick();
  endtask

  int          q[$];
  int          cur;
  int          nlat;
  int          e;
  logic [15:0] last_l;
  logic [15:0] last_r;
  logic        acc_prev;
  logic        fr;
  logic        hs;

  initial begin
    reset_n = 1'b0;
    sample_left = '0;
    sample_right = '0;
    sample_valid = 1'b0;
    PCM_Playback_Accept = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 32'(sample_ready), 32'd0);
    chk("rst_pcmL", 32'(PCM_Playback_Left), 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_ucnt", 32'(underrun_count), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("rel_ready0", 32'(sample_ready), 32'd0);
    tick();
    chk("rel_ready1", 32'(sample_ready), 32'd1);

    // 1: single pair appears in the frame cycle, then stays until the next rise
    push(16'h1234, 16'hABCD);
    chk("t1_fill1", 32'(fill_level), 32'd1);
    chk("t1_pre_L", 32'(PCM_Playback_Left), 32'd0);
    PCM_Playback_Accept = 1'b1;
    #1;
    chk("t1_frm_L", 32'(PCM_Playback_Left), 32'h1234);
    chk("t1_frm_R", 32'(PCM_Playback_Right), 32'hABCD);
    tick();
    chk("t1_fill0", 32'(fill_level), 32'd0);
    chk("t1_held_L", 32'(PCM_Playback_Left), 32'h1234);
    chk("t1_no_urun", 32'(underrun), 32'd0);
    repeat (15) tick();
    PCM_Playback_Accept = 1'b0;
    chk("t1_hi_L", 32'(PCM_Playback_Left), 32'h1234);
    repeat (16) tick();
    chk("t1_lo_R", 32'(PCM_Playback_Right), 32'hABCD);

    // 2: fill to DEPTH, fifth pair waits for a frame, order preserved
    for (int k = 1; k <= 4; k++) push(16'(16'h1000 + k), 16'(16'h2000 + k));
    chk("t2_fill4", 32'(fill_level), 32'd4);
    chk("t2_ready0", 32'(sample_ready), 32'd0);
    sample_left = 16'h1005;
    sample_right = 16'h2005;
    sample_valid = 1'b1;
    tick();
    chk("t2_stall_fill", 32'(fill_level), 32'd4);
    PCM_Playback_Accept = 1'b1;
    #1;
    chk("t2_p1_L", 32'(PCM_Playback_Left), 32'h1001);
    chk("t2_p1_R", 32'(PCM_Playback_Right), 32'h2001);
    tick();
    chk("t2_fill3", 32'(fill_level), 32'd3);
    chk("t2_ready1", 32'(sample_ready), 32'd1);
    tick();
    sample_valid = 1'b0;
    chk("t2_fill4b", 32'(fill_level), 32'd4);
    PCM_Playback_Accept = 1'b0;
    tick();
    for (int k = 2; k <= 5; k++) frame_chk("t2_pk", 16'(16'h1000 + k), 16'(16'h2000 + k));
    chk("t2_empty", 32'(fill_level), 32'd0);

    // 3: underruns repeat the held pair and saturate the counter
    for (int k = 0; k < 3; k++) begin
      PCM_Playback_Accept = 1'b1;
      #1;
      chk("t3_hold_L", 32'(PCM_Playback_Left), 32'h1005);
      tick();
      chk("t3_urun_hi", 32'(underrun), 32'd1);
      PCM_Playback_Accept = 1'b0;
      tick();
      chk("t3_urun_lo", 32'(underrun), 32'd0);
    end
    chk("t3_cnt3", 32'(underrun_count), 32'd3);
    repeat (300) begin
      PCM_Playback_Accept = 1'b1;
      tick();
      PCM_Playback_Accept = 1'b0;
      tick();
    end
    chk("t3_cnt_sat", 32'(underrun_count), 32'd255);
    chk("t3_hold_R", 32'(PCM_Playback_Right), 32'h2005);

    // 4: push coincident with a pop at level 2
    push(16'h0A01, 16'h0B01);
    push(16'h0A02, 16'h0B02);
    sample_left = 16'h0A03;
    sample_right = 16'h0B03;
    sample_valid = 1'b1;
    PCM_Playback_Accept = 1'b1;
    #1;
    chk("t4_pop_L", 32'(PCM_Playback_Left), 32'h0A01);
    tick();
    chk("t4_fill2", 32'(fill_level), 32'd2);
    chk("t4_held_R", 32'(PCM_Playback_Right), 32'h0B01);
    sample_valid = 1'b0;
    PCM_Playback_Accept = 1'b0;
    tick();
    frame_chk("t4_B", 16'h0A02, 16'h0B02);
    frame_chk("t4_C", 16'h0A03, 16'h0B03);

    // 5: reset mid-stream with 3 pairs stored and Accept held high
    for (int k = 1; k <= 4; k++) push(16'(16'h0D00 + k), 16'(16'h0E00 + k));
    PCM_Playback_Accept = 1'b1;
    tick();
    chk("t5_fill3", 32'(fill_level), 32'd3);
    chk("t5_held_L", 32'(PCM_Playback_Left), 32'h0D01);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_L", 32'(PCM_Playback_Left), 32'd0);
    chk("t5_rst_fill", 32'(fill_level), 32'd0);
    chk("t5_rst_ready", 32'(sample_ready), 32'd0);
    chk("t5_rst_cnt", 32'(underrun_count), 32'd0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("t5_rel_ready0", 32'(sample_ready), 32'd0);
    tick();
    chk("t5_ready1", 32'(sample_ready), 32'd1);
    chk("t5_urun", 32'(underrun), 32'd1);
    chk("t5_cnt1", 32'(underrun_count), 32'd1);
    chk("t5_out0", 32'(PCM_Playback_Right), 32'd0);
    PCM_Playback_Accept = 1'b0;
    tick();
    chk("t5_urun_lo", 32'(underrun), 32'd0);

    // 6: ramp stream against a queue model; outputs may change only in frame cycles
    cur = 0;
    nlat = 0;
    last_l = '0;
    last_r = '0;
    acc_prev = PCM_Playback_Accept;
    for (int cyc = 0; cyc < 3000 && nlat < 40; cyc++) begin
      sample_valid = (cur < 40);
      sample_left  = 16'(cur * 7);
      sample_right = 16'hFFFF - 16'(cur * 7);
      PCM_Playback_Accept = (cyc % 8) < 4;
      #1;
      fr = PCM_Playback_Accept & ~acc_prev;
      hs = sample_valid & sample_ready;
      chk("t6_fill", 32'(fill_level), 32'(q.size()));
      if (fr && q.size() > 0) begin
        e = q.pop_front();
        last_l = 16'(e * 7);
        last_r = 16'hFFFF - 16'(e * 7);
        nlat++;
      end
      chk("t6_L", 32'(PCM_Playback_Left), 32'(last_l));
      chk("t6_R", 32'(PCM_Playback_Right), 32'(last_r));
      if (hs) begin
        q.push_back(cur);
        cur++;
      end
      acc_prev = PCM_Playback_Accept;
      @(posedge clk);
      #1;
    end
    chk("t6_all_latched", 32'(nlat), 32'd40);
    sample_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
